led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Round controller for the memory game. Each round it generates a pseudo-random pattern of LED indices and plays it on the 8 LEDs with programmable on/off timing. It then collects the player's button presses and checks them step by step against the stored pattern. It sits between the game FSM, which supplies start, length and seed and consumes pass/fail, and the raw LED and button pins, so the game FSM never drives LEDs or samples buttons directly.

## Interface
- MAX_LEN, 16: pattern storage depth (steps).
- TICK_DIV, 100: clk_2 cycles per timing tick.
- ON_TICKS, 4: ticks each pattern LED stays lit.
- OFF_TICKS, 2: dark ticks after each pattern LED.
- TIMEOUT_TICKS, 500: ticks allowed between player presses.

Ports:
- clk_2  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start round; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- level_len  in  5  steps this round. Legal range 1..MAX_LEN; 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- seed  in  8  LFSR seed, captured on start.
- btn  in  8  player buttons, active-high, already debounced.
- led  out  8  LED drive.
- busy  out  1  high in every state except IDLE.
- input_phase  out  1  high in INPUT.
- done  out  1  one-cycle pulse when a round ends.
- pass  out  1  result of the last round; held until the next start.
- fail  out  1  complement of pass after a round; held until the next start.
- err_step  out  5  step index of the first mismatch or timeout.

## Operation
- States are IDLE, LOAD, SHOW_ON, SHOW_OFF, INPUT and RESULT.
- IDLE:
  - Outputs led=0, busy=0.
  - start=1 latches the clamped length into len_q and the seed into lfsr, then moves to LOAD.
  - A seed of 0x00 is replaced with 0xA5.
  - start=1 clears pass, fail and err_step.
- LOAD:
  - One LFSR shift per cycle: new = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]; lfsr <= {lfsr[6:0], new}.
  - After each shift, step[i] <= the new lfsr[2:0].
  - Runs exactly len_q cycles, then moves to SHOW_ON with step index 0.
- SHOW_ON: led = one-hot(step[idx]) for ON_TICKS ticks, then move to SHOW_OFF.
- SHOW_OFF:
  - led=0 for OFF_TICKS ticks.
  - Then idx+1; return to SHOW_ON if idx < len_q-1, otherwise move to INPUT with idx=0.
- The tick prescaler clears on every state entry, so phase durations are exact multiples of TICK_DIV cycles.
- INPUT:
  - Rising-edge detect on btn: rise = btn & ~btn_q, where btn_q is btn registered, clear at reset.
  - led = btn (live echo).
  - rise with exactly one bit set, matching step[idx]: idx+1 and the timeout counter clears. If that was the last step, pass=1 and move to RESULT.
  - rise with exactly one bit set, mismatching: fail=1, err_step=idx, move to RESULT.
  - rise with two or more bits in the same cycle counts as a mismatch.
  - rise = 0: no action.
  - Timeout counter reaching TIMEOUT_TICKS gives fail=1, err_step=idx, move to RESULT.
- RESULT: done=1 for one cycle, led=0, then move to IDLE.
- abort=1 in any state:
  - Next state is IDLE and led=0.
  - No done pulse; pass and fail stay 0.
  - abort has priority over start and over any button event in the same cycle.

## Timing
- Reset values: led=0, busy=0, input_phase=0, done=0, pass=0, fail=0, err_step=0, state IDLE, lfsr=0xA5.
- All outputs are registered.
- start sampled in cycle 0 gives busy=1 in cycle 1.
- LOAD occupies cycles 1..len_q. The first LED is lit from cycle len_q+1.
- Show phase lasts len_q*(ON_TICKS+OFF_TICKS)*TICK_DIV cycles exactly.
- Press latency: a button rising in cycle t is evaluated at t+1. The resulting pass, fail or state change is visible at t+2, and done pulses the cycle after RESULT is entered.
- Buttons held from before INPUT is entered produce no edge and count nothing.
- Reset asserted mid-round clears everything asynchronously. The stored pattern need not be cleared.

## Test plan
- Pattern generation: seed=0x01, level_len=4, TICK_DIV=2, ON_TICKS=1, OFF_TICKS=1 -> led sequence 0x04, 0x00, 0x10, 0x00, 0x01, 0x00, 0x02, 0x00, each held 2 cycles, then input_phase=1.
- Correct input: same round, pulse btn bits 2, 4, 0, 1 one at a time -> done pulse, pass=1, fail=0.
- Wrong press: same round, pulse bits 2 then 5 -> fail=1, err_step=1, done pulses once.
- Simultaneous press: in INPUT, rise on btn=0x05 in one cycle -> fail=1, err_step=0.
- Timeout: TIMEOUT_TICKS=3, no presses -> fail=1 exactly 3*TICK_DIV cycles after input_phase rises. Separately, level_len=0 -> a 1-step round.
- Abort and reset: abort during SHOW_ON -> IDLE next cycle, led=0, no done, start accepted again. rst_n low during INPUT -> all outputs 0 immediately.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Memory-game round controller: generates an LFSR pattern, plays it on the LEDs,
// then checks the player's button presses step by step against it.
module led_pattern_sequencer #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TICK_DIV      = 100,
  parameter int unsigned ON_TICKS      = 4,
  parameter int unsigned OFF_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 500
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] level_len,
  input  logic [7:0] seed,
  input  logic [7:0] btn,
  output logic [7:0] led,
  output logic       busy,
  output logic       input_phase,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [4:0] err_step
);

  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TickW  = $clog2(TIMEOUT_TICKS + ON_TICKS + OFF_TICKS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShowOn,
    StShowOff,
    StInput,
    StResult
  } state_e;

  state_e            state_q;
  logic [4:0]        len_q;
  logic [4:0]        idx_q;
  logic [7:0]        lfsr_q;
  logic [2:0]        step_q [MAX_LEN];
  logic [PrescW-1:0] presc_q;
  logic [TickW-1:0]  tick_cnt_q;
  logic [7:0]        btn_q;
  logic [7:0]        rise_q;

  logic       tick;
  logic       last_step;
  logic [7:0] lfsr_nxt;
  logic [4:0] len_clamp;
  logic [4:0] idx_inc;
  logic [2:0] cur_step;
  logic [2:0] next_step;

  function automatic logic [7:0] onehot(input logic [2:0] sel);
    onehot = 8'd1 << sel;
  endfunction

  always_comb begin
    tick      = (presc_q == PrescW'(TICK_DIV - 1));
    lfsr_nxt  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    last_step = (idx_q == len_q - 5'd1);
    idx_inc   = idx_q + 5'd1;
    cur_step  = step_q[idx_q[IdxW-1:0]];
    next_step = step_q[idx_inc[IdxW-1:0]];
    if (level_len == 5'd0) begin
      len_clamp = 5'd1;
    end else if (level_len > 5'(MAX_LEN)) begin
      len_clamp = 5'(MAX_LEN);
    end else begin
      len_clamp = level_len;
    end
  end

  // Pattern storage needs no reset; it is always rewritten in LOAD before use.
  always_ff @(posedge clk_2) begin
    if (state_q == StLoad) begin
      step_q[idx_q[IdxW-1:0]] <= lfsr_nxt[2:0];
    end
  end

  // Registered rise so a press in cycle t is evaluated in cycle t+1.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      rise_q <= '0;
    end else begin
      btn_q  <= btn;
      rise_q <= btn & ~btn_q;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= 5'd1;
      idx_q       <= '0;
      lfsr_q      <= 8'hA5;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      led         <= '0;
      busy        <= 1'b0;
      input_phase <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      err_step    <= '0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        presc_q    <= '0;
        tick_cnt_q <= tick_cnt_q + TickW'(1);
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end

      if (abort) begin
        state_q     <= StIdle;
        led         <= '0;
        busy        <= 1'b0;
        input_phase <= 1'b0;
        // An aborted round reports no result; a finished one stays visible in IDLE.
        if (state_q != StIdle) begin
          pass     <= 1'b0;
          fail     <= 1'b0;
          err_step <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            led <= '0;
            if (start) begin
              len_q      <= len_clamp;
              lfsr_q     <= (seed == 8'h00) ? 8'hA5 : seed;
              pass       <= 1'b0;
              fail       <= 1'b0;
              err_step   <= '0;
              idx_q      <= '0;
              busy       <= 1'b1;
              presc_q    <= '0;
              tick_cnt_q <= '0;
              state_q    <= StLoad;
            end
          end

          StLoad: begin
            lfsr_q <= lfsr_nxt;
            if (last_step) begin
              idx_q      <= '0;
              // With a 1-step round, step 0 is being written this very cycle.
              led        <= onehot((idx_q == 5'd0) ? lfsr_nxt[2:0] : step_q[0]);
              presc_q    <= '0;
              tick_cnt_q <= '0;
              state_q    <= StShowOn;
            end else begin
              idx_q <= idx_inc;
            end
          end

          StShowOn: begin
            if (tick && tick_cnt_q == TickW'(ON_TICKS - 1)) begin
              led        <= '0;
              presc_q    <= '0;
              tick_cnt_q <= '0;
              state_q    <= StShowOff;
            end
          end

          StShowOff: begin
            if (tick && tick_cnt_q == TickW'(OFF_TICKS - 1)) begin
              presc_q    <= '0;
              tick_cnt_q <= '0;
              if (last_step) begin
                idx_q       <= '0;
                led         <= btn;
                input_phase <= 1'b1;
                state_q     <= StInput;
              end else begin
                idx_q   <= idx_inc;
                led     <= onehot(next_step);
                state_q <= StShowOn;
              end
            end
          end

          StInput: begin
            led <= btn;
            if (rise_q != 8'd0) begin
              // Equality with a one-hot value also rejects multi-button rises.
              if (rise_q == onehot(cur_step)) begin
                presc_q    <= '0;
                tick_cnt_q <= '0;
                if (last_step) begin
                  pass        <= 1'b1;
                  led         <= '0;
                  input_phase <= 1'b0;
                  state_q     <= StResult;
                end else begin
                  idx_q <= idx_inc;
                end
              end else begin
                fail        <= 1'b1;
                err_step    <= idx_q;
                led         <= '0;
                input_phase <= 1'b0;
                presc_q     <= '0;
                tick_cnt_q  <= '0;
                state_q     <= StResult;
              end
            end else if (tick && tick_cnt_q == TickW'(TIMEOUT_TICKS - 1)) begin
              fail        <= 1'b1;
              err_step    <= idx_q;
              led         <= '0;
              input_phase <= 1'b0;
              presc_q     <= '0;
              tick_cnt_q  <= '0;
              state_q     <= StResult;
            end
          end

          StResult: begin
            done    <= 1'b1;
            led     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end

          default: begin
            led     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: stimulus pushes expected LED/done events with
// their cycle numbers; a negedge monitor pops and compares them as they appear.
module tb_led_pattern_sequencer;

  logic       clk_2 = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] level_len = '0;
  logic [7:0] seed = '0;
  logic [7:0] btn = '0;
  logic [7:0] led;
  logic       busy;
  logic       input_phase;
  logic       done;
  logic       pass;
  logic       fail;
  logic [4:0] err_step;

  led_pattern_sequencer #(
    .MAX_LEN      (16),
    .TICK_DIV     (2),
    .ON_TICKS     (1),
    .OFF_TICKS    (1),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk_2      (clk_2),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .level_len  (level_len),
    .seed       (seed),
    .btn        (btn),
    .led        (led),
    .busy       (busy),
    .input_phase(input_phase),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .err_step   (err_step)
  );

  always #5 clk_2 = ~clk_2;

  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] led_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input bit is_done, input logic [7:0] v, input int at);
    exp_t e;
    e.is_done = is_done;
    e.val     = v;
    e.at      = at;
    expq.push_back(e);
  endtask

  task automatic pop_check(input bit is_done, input logic [7:0] v);
    exp_t e;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got %s 0x%0h at cycle %0d, expected none",
               is_done ? "done" : "led", v, cyc);
    end else begin
      e = expq.pop_front();
      check(is_done ? "done_result" : "led_value", 32'({is_done, v}), 32'({e.is_done, e.val}));
      check("event_cycle", cyc, e.at);
    end
  endtask

  always @(negedge clk_2) begin
    if (led !== led_prev) begin
      pop_check(1'b0, led);
      led_prev <= led;
    end
    if (done === 1'b1) pop_check(1'b1, {1'b0, pass, fail, err_step});
  end

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic start_round(input logic [4:0] l, input logic [7:0] s, output int c0);
    check("idle_before_start", 32'(busy), 32'd0);
    level_len = l;
    seed      = s;
    start     = 1'b1;
    c0        = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("result_cleared", 32'({pass, fail, err_step}), 32'd0);
  endtask

  // Pattern of seed 0x01: steps 2,4,0,1; first LED at c0+5, every LED/gap 2 cycles.
  task automatic push_show4(input int c0);
    logic [7:0] pat [4];
    pat[0] = 8'h04;
    pat[1] = 8'h10;
    pat[2] = 8'h01;
    pat[3] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      push_ev(1'b0, pat[i], c0 + 5 + 4 * i);
      push_ev(1'b0, 8'h00, c0 + 7 + 4 * i);
    end
  endtask

  task automatic wait_input(input int exp_c, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      if (input_phase === 1'b1) begin
        t = cyc;
        break;
      end
      tick();
    end
    check("input_phase_cycle", t, exp_c);
  endtask

  task automatic press(input logic [7:0] v);
    btn = v;
    tick();
    btn = '0;
    tick();
  endtask

  initial begin
    int c0;
    int t;
    logic [7:0] seq [4];
    seq[0] = 8'h04;
    seq[1] = 8'h10;
    seq[2] = 8'h01;
    seq[3] = 8'h02;

    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", 32'({led, busy, input_phase, done, pass, fail, err_step}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'({led, busy, input_phase, done, pass, fail, err_step}), 32'd0);

    // Pattern playback then a fully correct answer.
    start_round(5'd4, 8'h01, c0);
    push_show4(c0);
    wait_input(c0 + 21, t);
    for (int i = 0; i < 4; i++) begin
      push_ev(1'b0, seq[i], t + 1 + 2 * i);
      push_ev(1'b0, 8'h00, t + 2 + 2 * i);
    end
    push_ev(1'b1, 8'h40, t + 9);
    for (int i = 0; i < 4; i++) press(seq[i]);
    repeat (2) tick();
    check("pass_held", 32'({pass, fail, err_step}), 32'h40);

    // Wrong second press.
    start_round(5'd4, 8'h01, c0);
    push_show4(c0);
    wait_input(c0 + 21, t);
    push_ev(1'b0, 8'h04, t + 1);
    push_ev(1'b0, 8'h00, t + 2);
    push_ev(1'b0, 8'h20, t + 3);
    push_ev(1'b0, 8'h00, t + 4);
    push_ev(1'b1, 8'h21, t + 5);
    press(8'h04);
    press(8'h20);
    repeat (3) tick();
    check("fail_held", 32'({pass, fail, err_step}), 32'h21);

    // Two buttons rising together.
    start_round(5'd4, 8'h01, c0);
    push_show4(c0);
    wait_input(c0 + 21, t);
    push_ev(1'b0, 8'h05, t + 1);
    push_ev(1'b0, 8'h00, t + 2);
    push_ev(1'b1, 8'h20, t + 3);
    press(8'h05);
    repeat (2) tick();

    // Timeout after 3 ticks of 2 cycles.
    start_round(5'd4, 8'h01, c0);
    push_show4(c0);
    wait_input(c0 + 21, t);
    push_ev(1'b1, 8'h20, t + 7);
    repeat (5) tick();
    check("no_fail_before_timeout", 32'(fail), 32'd0);
    tick();
    check("fail_at_timeout", 32'({fail, err_step}), 32'h20);
    repeat (2) tick();

    // Abort during the first SHOW_ON cycle.
    start_round(5'd4, 8'h01, c0);
    push_ev(1'b0, 8'h04, c0 + 5);
    push_ev(1'b0, 8'h00, c0 + 6);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", 32'({led, busy, input_phase, pass, fail}), 32'd0);
    repeat (3) tick();

    // Length 0 runs as 1 step; seed 0 becomes 0xA5 giving step 2.
    start_round(5'd0, 8'h00, c0);
    push_ev(1'b0, 8'h04, c0 + 2);
    push_ev(1'b0, 8'h00, c0 + 4);
    wait_input(c0 + 6, t);
    push_ev(1'b0, 8'h04, t + 1);
    push_ev(1'b0, 8'h00, t + 2);
    push_ev(1'b1, 8'h40, t + 3);
    press(8'h04);
    repeat (2) tick();

    // Asynchronous reset while waiting for input.
    start_round(5'd0, 8'h00, c0);
    push_ev(1'b0, 8'h04, c0 + 2);
    push_ev(1'b0, 8'h00, c0 + 4);
    wait_input(c0 + 6, t);
    check("busy_in_input", 32'({busy, input_phase}), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({led, busy, input_phase, done, pass, fail, err_step}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    check("scoreboard_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time 100000, expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
